// File: rtl/instr_encoder_if.sv
// Field-bundle input and instruction-word output handshakes of the instruction encoder.
// The master side produces field bundles and consumes words; the slave side is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cls;
  logic [2:0]  in_f3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_cls, in_f3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_cls, in_f3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes R/LOAD/STORE/BRANCH field bundles into 32-bit instruction words and
// streams them out through a small circular FIFO; illegal bundles are dropped with an err pulse.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          issue;
  logic          illegal;
  logic          push;
  logic [31:0]   enc_word;

  assign accept  = bus.in_valid && bus.in_ready;
  assign issue   = bus.out_valid && bus.out_ready;
  assign illegal = bus.in_cls[2] || ((bus.in_cls[1:0] == 2'b11) && bus.in_imm[0]);
  assign push    = accept && !illegal;

  // Ready is held low during reset so nothing is accepted while state is being cleared.
  assign bus.in_ready  = !rst && (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'h0;

  always_comb begin
    enc_word = 32'h0;
    case (bus.in_cls[1:0])
      2'b00: enc_word = {(bus.in_alt ? 7'b0100000 : 7'b0000000), bus.in_rs2, bus.in_rs1,
                         bus.in_f3, bus.in_rd, 7'b1110011};
      2'b01: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_f3, bus.in_rd, 7'b1101011};
      2'b10: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_f3,
                         bus.in_imm[4:0], 7'b1000011};
      default: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                           bus.in_f3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
    endcase
  end

  // Storage is deliberately not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, illegal drops, backpressure, streaming and reset.
module tb_instr_encoder;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       err;
  int         total;
  int         bad;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic alt, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {(alt ? 7'b0100000 : 7'b0000000), rs2, rs1, f3, rd, 7'b1110011};
  endfunction

  task automatic set_bundle(input logic v, input logic [2:0] cls, input logic [2:0] f3,
                            input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [12:0] imm);
    bus.in_valid = v;
    bus.in_cls   = cls;
    bus.in_f3    = f3;
    bus.in_alt   = alt;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    set_bundle(1'b0, 3'b000, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
    #1 rst = 1'b1;
    #2;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_r_encode();
    @(negedge clk);
    set_bundle(1'b1, 3'b000, 3'b000, 1'b0, 5'd5, 5'd21, 5'd31, 13'd0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL r0_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'b00000001111110101000001011110011) begin bad++; $display("[TB] FAIL r0_word: got %h want 01FA82F3", bus.out_instr); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL r0_count: got %0d want 1", count); end
    // Second bundle is accepted on the same edge the first issues.
    @(negedge clk);
    set_bundle(1'b1, 3'b000, 3'b001, 1'b1, 5'd16, 5'd12, 5'd10, 13'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_instr !== 32'b01000000101001100001100001110011) begin bad++; $display("[TB] FAIL r1_word: got %h want 40A61873", bus.out_instr); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL r1_count: got %0d want 1", count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL r_drain_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("[TB] FAIL r_drain_word: got %h want 0", bus.out_instr); end
  endtask

  task automatic test_imm_formats();
    @(negedge clk);
    set_bundle(1'b1, 3'b001, 3'b010, 1'b1, 5'd7, 5'd8, 5'd0, 13'h1FFC);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_instr !== 32'hFFC423EB) begin bad++; $display("[TB] FAIL load_word: got %h want FFC423EB", bus.out_instr); end
    @(negedge clk);
    set_bundle(1'b1, 3'b010, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 13'd20);
    @(posedge clk); #1;
    total++; if (bus.out_instr !== 32'h00312A43) begin bad++; $display("[TB] FAIL store_word: got %h want 00312A43", bus.out_instr); end
    @(negedge clk);
    set_bundle(1'b1, 3'b011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'd8);
    @(posedge clk); #1;
    total++; if (bus.out_instr !== 32'h00208463) begin bad++; $display("[TB] FAIL branch_word: got %h want 00208463", bus.out_instr); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL imm_count: got %0d want 1", count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL imm_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_bundle(1'b1, 3'b101, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ill_cls_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ill_cls_err: got %b want 1", err); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL ill_cls_count: got %0d want 0", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ill_cls_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    set_bundle(1'b1, 3'b011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'd9);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ill_br_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ill_br_err: got %b want 1", err); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL ill_br_count: got %0d want 0", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ill_br_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    set_bundle(1'b1, 3'b001, 3'b010, 1'b0, 5'd7, 5'd8, 5'd0, 13'h1FFC);
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL ill_err_clear: got %b want 0", err); end
    // Illegal accept coinciding with an issue: count drops, err still pulses.
    @(negedge clk);
    set_bundle(1'b1, 3'b100, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL ill_issue_count: got %0d want 0", count); end
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ill_issue_err: got %b want 1", err); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL ill_issue_err_clear: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) begin
      w[i] = enc_r(1'b0, 5'(i + 3), 5'(i + 2), 3'(i), 5'(i + 1));
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_bundle(1'b1, 3'b000, 3'(i), 1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 13'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL full_count: got %0d want 4", count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_instr !== w[0]) begin bad++; $display("[TB] FAIL full_hold_word: got %h want %h", bus.out_instr, w[0]); end
    bus.out_ready = 1'b1;
    total++; if (bus.out_instr !== w[0]) begin bad++; $display("[TB] FAIL bp_word0: got %h want %h", bus.out_instr, w[0]); end
    @(posedge clk); #1;
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL bp_count_after0: got %0d want 3", count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_rise: got %b want 1", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.out_instr !== w[1]) begin bad++; $display("[TB] FAIL bp_word1: got %h want %h", bus.out_instr, w[1]); end
    @(posedge clk); #1;
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL bp_count_fifth: got %0d want 3", count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      total++; if (bus.out_instr !== w[k]) begin bad++; $display("[TB] FAIL bp_word%0d: got %h want %h", k, bus.out_instr, w[k]); end
      @(posedge clk); #1;
      total++; if (count !== 3'(4 - k)) begin bad++; $display("[TB] FAIL bp_count%0d: got %0d want %0d", k, count, 4 - k); end
      @(negedge clk);
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [10];
    for (int i = 0; i < 10; i++) begin
      w[i] = enc_r(i[0], 5'(31 - i), 5'(i + 2), 3'(i), 5'(i + 1));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_bundle(1'b1, 3'b000, 3'd0, 1'b0, 5'd1, 5'd2, 5'd31, 13'd0);
    @(posedge clk); #1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== w[i - 1]) begin bad++; $display("[TB] FAIL stream_word%0d: got %b/%h want 1/%h", i - 1, bus.out_valid, bus.out_instr, w[i - 1]); end
      set_bundle(1'b1, 3'b000, 3'(i), i[0], 5'(i + 1), 5'(i + 2), 5'(31 - i), 13'd0);
      @(posedge clk); #1;
      total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL stream_count%0d: got %0d want 1", i, count); end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== w[9]) begin bad++; $display("[TB] FAIL stream_word9: got %h want %h", bus.out_instr, w[9]); end
    @(posedge clk); #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL stream_final_count: got %0d want 0", count); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_bundle(1'b1, 3'b001, 3'b000, 1'b0, 5'(i + 1), 5'd4, 5'd0, 13'(i * 4));
      @(posedge clk); #1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL pre_rst_count: got %0d want 3", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL mid_rst_count: got %0d want 0", count); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_word: got %h want 0", bus.out_instr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready: got %b want 1", bus.in_ready); end
    set_bundle(1'b1, 3'b010, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 13'd20);
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00312A43) begin bad++; $display("[TB] FAIL post_rst_word: got %b/%h want 1/00312A43", bus.out_valid, bus.out_instr); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL post_rst_count: got %0d want 1", count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_r_encode();
    test_imm_formats();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the control-logic decoder. The block takes instruction fields (class, funct3, register addresses, immediate) over a valid/ready handshake and encodes them into 32-bit instruction words in the team's ISA format. It buffers the words in a small FIFO and streams them out over a second valid/ready handshake. It sits upstream of the instruction register and serves as the program-generation source for decoder and datapath benches.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle
- in_cls  input  3  class: 000 R, 001 LOAD, 010 STORE, 011 BRANCH, 1xx illegal
- in_f3  input  3  funct3
- in_alt  input  1  R only: 1 selects funct7=0100000 (SUB/SRA)
- in_rd, in_rs1, in_rs2  input  5 each  register addresses
- in_imm  input  13  immediate, two's complement
- out_valid  output  1  out_instr holds a valid word
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction (FIFO head)
- count  output  $clog2(DEPTH)+1  occupied entries
- err  output  1  one-cycle pulse: illegal bundle dropped

## Operation
- Accept occurs when in_valid && in_ready. Issue occurs when out_valid && out_ready.
- Encoding, MSB→LSB:
  - R: {in_alt?7'b0100000:7'b0000000, rs2, rs1, f3, rd, 7'b1110011}
  - LOAD: {imm[11:0], rs1, f3, rd, 7'b1101011}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1000011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}
- Fields a class does not use are ignored. in_alt is ignored outside R. in_imm[12] is ignored for LOAD/STORE.
- A bundle is illegal if in_cls[2]=1, or if it is BRANCH with in_imm[0]=1. An illegal bundle is consumed (handshake completes) and not enqueued. err pulses high in the following cycle.
- FIFO: circular buffer with wrapping read/write pointers. count = writes − reads.
- in_ready = (count < DEPTH). There is no pass-through when full.
- out_valid = (count != 0). out_instr = mem[rd_ptr] when out_valid, else 32'h0.
- Simultaneous accept and issue: count unchanged, both pointers advance.
- Simultaneous illegal accept and issue: count decrements by 1, err pulses.

## Timing
- Reset (async assert): count=0, pointers=0, out_valid=0, out_instr=0, err=0. in_ready=0 while rst is high and 1 in the first cycle after release. FIFO contents are not cleared and are unobservable.
- Reset mid-stream discards all queued words. No partial issue follows.
- Latency: a legal bundle accepted at edge N is on out_instr with out_valid=1 after edge N (first cycle N+1) if the FIFO was empty.
- While out_valid && !out_ready, out_instr and out_valid hold stable.
- Throughput: one accept and one issue per cycle, sustained.
- Full: in_ready=0 in the cycle count==DEPTH. It rises in the cycle after an issue.
- Empty: out_valid=0 in the cycle after the last issue when no accept coincides.
- err is registered. It is high exactly one cycle after the illegal accept edge.

## Test plan
- R encode: cls=000, rd=5, rs1=21, rs2=31, f3=000, alt=0 → out_instr=32'b00000001111110101000001011110011 one cycle later. Then alt=1, rd=16, rs1=12, rs2=10, f3=001 → 32'b01000000101001100001100001110011.
- Immediate formats:
  - LOAD rd=7, rs1=8, f3=010, imm=−4 (13'h1FFC) → 32'hFFC423EB
  - STORE rs1=2, rs2=3, f3=010, imm=20 → 32'h00312A43
  - BRANCH rs1=1, rs2=2, f3=000, imm=8 → 32'h00208463
- Illegal: cls=101, then BRANCH with imm=9 → both accepted (in_ready=1), err high one cycle each, count stays 0, out_valid stays 0.
- Backpressure/full: out_ready=0, push 5 legal bundles with DEPTH=4 → 4 accepted, count=4, in_ready=0, 5th held. Then out_ready=1 → words issue in order, 5th accepted, count drains to 0.
- Streaming: in_valid=out_ready=1 for 10 cycles with distinct R bundles → count stays 1, 10 words out in order, no gaps after the first, pointers wrap correctly.
- Reset mid-operation: 3 words queued, assert rst asynchronously mid-cycle → out_valid, count, and out_instr go to 0 immediately. After release, in_ready=1 and a new bundle appears with 1-cycle latency.
